lift_plant_model: RTL

- Cycle-accurate environment model of the lift car, driven by a lift controller's command outputs; it returns the sensor signals the controller consumes.
- Models car travel between floors, door motion, floor-call latching and safety interlocks.
- Used as the closed-loop counterpart in controller benchmarks and trojan-detection benches, and as a reusable plant for equivalence/stress runs.

---
 rtl/lift_plant_if.sv | 34 +++
 rtl/lift_plant_model.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lift_plant_if.sv
// Command/sensor bundle between a lift controller (master) and the lift plant model (slave).
interface lift_plant_if #(
  parameter int unsigned NUM_FLOORS = 8,
  parameter int unsigned FLOOR_W    = 3
);
  logic                  motor_up;
  logic                  motor_down;
  logic                  door_open_cmd;
  logic                  door_close_cmd;
  logic [NUM_FLOORS-1:0] call_req;

  logic [FLOOR_W-1:0]    floor;
  logic                  at_floor;
  logic                  moving;
  logic                  dir_up;
  logic                  door_opened;
  logic                  door_closed;
  logic                  top_limit;
  logic                  bottom_limit;
  logic [NUM_FLOORS-1:0] call_pending;
  logic                  fault;

  modport master (
    output motor_up, motor_down, door_open_cmd, door_close_cmd, call_req,
    input  floor, at_floor, moving, dir_up, door_opened, door_closed,
           top_limit, bottom_limit, call_pending, fault
  );

  modport slave (
    input  motor_up, motor_down, door_open_cmd, door_close_cmd, call_req,
    output floor, at_floor, moving, dir_up, door_opened, door_closed,
           top_limit, bottom_limit, call_pending, fault
  );
endinterface

// File: rtl/lift_plant_model.sv
// Cycle-accurate lift car environment: car travel, door motion, call latching and
// interlock fault detection. Every sensor output comes straight from a flop.
module lift_plant_model #(
  parameter int unsigned NUM_FLOORS    = 8,
  parameter int unsigned FLOOR_W       = 3,
  parameter int unsigned TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_CYCLES   = 8
) (
  input  logic         clk,
  input  logic         rst,
  lift_plant_if.slave  lift_if
);

  localparam int unsigned TCNT_W = $clog2(TRAVEL_CYCLES);
  localparam int unsigned DCNT_W = $clog2(DOOR_CYCLES);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] BOT_FLOOR = '0;
  localparam logic [TCNT_W-1:0]  TRAVEL_LOAD = TCNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [DCNT_W-1:0]  DOOR_LOAD   = DCNT_W'(DOOR_CYCLES - 1);

  typedef enum logic {
    CAR_PARKED,
    CAR_TRAVEL
  } car_state_e;

  typedef enum logic [1:0] {
    DOOR_CLOSED,
    DOOR_OPENING,
    DOOR_OPEN,
    DOOR_CLOSING
  } door_state_e;

  car_state_e            car_q, car_d;
  door_state_e           door_q, door_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic [DCNT_W-1:0]     dcnt_q, dcnt_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  dir_up_q, dir_up_d;
  logic                  at_floor_q, at_floor_d;
  logic                  moving_q, moving_d;
  logic                  door_opened_q, door_opened_d;
  logic                  door_closed_q, door_closed_d;
  logic                  top_limit_q, top_limit_d;
  logic                  bottom_limit_q, bottom_limit_d;
  logic [NUM_FLOORS-1:0] call_pending_q, call_pending_d;
  logic                  fault_q, fault_d;

  logic                  car_fault;
  logic                  door_fault;
  logic [NUM_FLOORS-1:0] call_clr;

  logic motor_up, motor_down, open_cmd, close_cmd;
  assign motor_up   = lift_if.motor_up;
  assign motor_down = lift_if.motor_down;
  assign open_cmd   = lift_if.door_open_cmd;
  assign close_cmd  = lift_if.door_close_cmd;

  // Car next state: start one floor of travel from PARKED, always finish it once started.
  // A same-edge door open request holds the car so the door and car never move together.
  always_comb begin
    car_d     = car_q;
    tcnt_d    = tcnt_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    car_fault = 1'b0;
    unique case (car_q)
      CAR_PARKED: begin
        if (motor_up && motor_down) begin
          car_fault = 1'b1;
        end else if ((motor_up || motor_down) && (door_q != DOOR_CLOSED)) begin
          car_fault = 1'b1;
        end else if (motor_up && (floor_q != TOP_FLOOR) && !open_cmd) begin
          car_d    = CAR_TRAVEL;
          dir_up_d = 1'b1;
          tcnt_d   = TRAVEL_LOAD;
        end else if (motor_down && (floor_q != BOT_FLOOR) && !open_cmd) begin
          car_d    = CAR_TRAVEL;
          dir_up_d = 1'b0;
          tcnt_d   = TRAVEL_LOAD;
        end
      end
      CAR_TRAVEL: begin
        if (tcnt_q == '0) begin
          car_d   = CAR_PARKED;
          floor_d = dir_up_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
        end else begin
          tcnt_d = tcnt_q - TCNT_W'(1);
        end
      end
      default: car_d = CAR_PARKED;
    endcase
  end

  // Door next state: open always wins over close; CLOSING reopens on any open request.
  always_comb begin
    door_d     = door_q;
    dcnt_d     = dcnt_q;
    door_fault = open_cmd && (car_q == CAR_TRAVEL);
    unique case (door_q)
      DOOR_CLOSED: begin
        if (open_cmd && (car_q == CAR_PARKED)) begin
          door_d = DOOR_OPENING;
          dcnt_d = DOOR_LOAD;
        end
      end
      DOOR_OPENING: begin
        if (dcnt_q == '0) begin
          door_d = DOOR_OPEN;
        end else begin
          dcnt_d = dcnt_q - DCNT_W'(1);
        end
      end
      DOOR_OPEN: begin
        if (close_cmd && !open_cmd) begin
          door_d = DOOR_CLOSING;
          dcnt_d = DOOR_LOAD;
        end
      end
      DOOR_CLOSING: begin
        if (open_cmd) begin
          door_d = DOOR_OPENING;
          dcnt_d = DOOR_LOAD;
        end else if (dcnt_q == '0) begin
          door_d = DOOR_CLOSED;
        end else begin
          dcnt_d = dcnt_q - DCNT_W'(1);
        end
      end
      default: door_d = DOOR_CLOSED;
    endcase
  end

  // Calls latch on request and clear while the door stands open at that floor; set wins.
  always_comb begin
    call_clr = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      call_clr[i] = (door_q == DOOR_OPEN) && (floor_q == FLOOR_W'(i));
    end
    call_pending_d = (call_pending_q & ~call_clr) | lift_if.call_req;
  end

  // Sensor values decoded from next state so the outputs land in flops.
  always_comb begin
    at_floor_d     = (car_d == CAR_PARKED);
    moving_d       = (car_d == CAR_TRAVEL);
    door_opened_d  = (door_d == DOOR_OPEN);
    door_closed_d  = (door_d == DOOR_CLOSED);
    top_limit_d    = (car_d == CAR_PARKED) && (floor_d == TOP_FLOOR);
    bottom_limit_d = (car_d == CAR_PARKED) && (floor_d == BOT_FLOOR);
    fault_d        = fault_q | car_fault | door_fault;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_q          <= CAR_PARKED;
      door_q         <= DOOR_CLOSED;
      tcnt_q         <= '0;
      dcnt_q         <= '0;
      floor_q        <= '0;
      dir_up_q       <= 1'b1;
      at_floor_q     <= 1'b1;
      moving_q       <= 1'b0;
      door_opened_q  <= 1'b0;
      door_closed_q  <= 1'b1;
      top_limit_q    <= 1'b0;
      bottom_limit_q <= 1'b1;
      call_pending_q <= '0;
      fault_q        <= 1'b0;
    end else begin
      car_q          <= car_d;
      door_q         <= door_d;
      tcnt_q         <= tcnt_d;
      dcnt_q         <= dcnt_d;
      floor_q        <= floor_d;
      dir_up_q       <= dir_up_d;
      at_floor_q     <= at_floor_d;
      moving_q       <= moving_d;
      door_opened_q  <= door_opened_d;
      door_closed_q  <= door_closed_d;
      top_limit_q    <= top_limit_d;
      bottom_limit_q <= bottom_limit_d;
      call_pending_q <= call_pending_d;
      fault_q        <= fault_d;
    end
  end

  assign lift_if.floor        = floor_q;
  assign lift_if.at_floor     = at_floor_q;
  assign lift_if.moving       = moving_q;
  assign lift_if.dir_up       = dir_up_q;
  assign lift_if.door_opened  = door_opened_q;
  assign lift_if.door_closed  = door_closed_q;
  assign lift_if.top_limit    = top_limit_q;
  assign lift_if.bottom_limit = bottom_limit_q;
  assign lift_if.call_pending = call_pending_q;
  assign lift_if.fault        = fault_q;

endmodule
